mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS-subset CPU.
- It replaces per-instruction combinational control so that the PC, IM/DM, register file, ALU and adder can be time-shared across cycles.
- It sits beside the PC/IM/ALU datapath in main and drives every mux select and write enable.
- Memory accesses use a ready handshake with a timeout watchdog.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_if.sv | 33 +++
 rtl/mc_ctrl_wait_cnt.sv | 32 +++
 rtl/mc_ctrl.sv | 141 ++++++++++++++
 tb/tb_mc_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared opcode, state and mux-select encodings for the multi-cycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Unsupported opcodes fall back to FETCH; the caller flags them as illegal.
    function automatic state_e decode_next(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = S_ADDIEX;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller-to-datapath control/handshake bundle
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, bus_err, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, bus_err, state_o
    );
endinterface

// File: rtl/mc_ctrl_wait_cnt.sv
// rtl/mc_ctrl_wait_cnt.sv - saturating memory-wait counter with timeout flag
module mc_wait_cnt #(
    parameter int CNT_W       = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= CNT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM with memory-ready timeout
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input logic       clock,
    input logic       reset,
    mc_ctrl_if.master ctl
);
    state_e state_q, state_d;
    logic   illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic   wait_state, cnt_en, cnt_clr, expired, timeout;
    ctrl_t  c;

    mc_wait_cnt #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_cnt (
        .clock   (clock),
        .reset   (reset),
        .en      (cnt_en),
        .clr     (cnt_clr),
        .expired (expired)
    );

    // mem_ready in the deciding cycle beats an expiring counter.
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout    = wait_state && !ctl.mem_ready && expired;
    assign cnt_en     = wait_state && !ctl.mem_ready;
    assign cnt_clr    = ctl.mem_ready || timeout || (state_d != state_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        bus_err_d = 1'b0;
        c         = '0;
        case (state_q)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_ALU;
                c.ir_we     = ctl.mem_ready;
                c.pc_we     = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                state_d     = decode_next(ctl.opcode);
                illegal_d   = (decode_next(ctl.opcode) == S_FETCH);
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                state_d     = (ctl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
                if (ctl.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                c.reg_we     = 1'b1;
                c.mem_to_reg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.i_or_d  = 1'b1;
                if (ctl.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
                state_d     = S_RWB;
            end
            S_RWB: begin
                c.reg_we  = 1'b1;
                c.reg_dst = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_ALUOUT;
                c.pc_we     = ctl.zero;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                c.pc_src = PC_JUMP;
                c.pc_we  = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                c.reg_we = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (timeout) begin
            state_d   = S_FETCH;
            bus_err_d = 1'b1;
        end
        // Nothing may be requested or written while reset is held.
        if (!reset) c = '0;
    end

    assign ctl.mem_req    = c.mem_req;
    assign ctl.mem_we     = c.mem_we;
    assign ctl.i_or_d     = c.i_or_d;
    assign ctl.ir_we      = c.ir_we;
    assign ctl.pc_we      = c.pc_we;
    assign ctl.pc_src     = c.pc_src;
    assign ctl.reg_we     = c.reg_we;
    assign ctl.reg_dst    = c.reg_dst;
    assign ctl.mem_to_reg = c.mem_to_reg;
    assign ctl.alu_src_a  = c.alu_src_a;
    assign ctl.alu_src_b  = c.alu_src_b;
    assign ctl.alu_op     = c.alu_op;
    assign ctl.illegal    = illegal_q;
    assign ctl.bus_err    = bus_err_q;
    assign ctl.state_o    = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a cycle-trace model
module tb_mc_ctrl;
    localparam int TMO = 15;
    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mc_ctrl_if dif ();
    mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (.clock(clock), .reset(reset), .ctl(dif));

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    logic        exp_rdy[$];
    logic [5:0]  exp_op[$];
    logic        exp_z[$];
    logic        pend_ill = 1'b0;
    logic        pend_berr = 1'b0;
    logic [5:0]  cur_op;
    logic        cur_z;
    logic [5:0]  legal_ops [6];

    wire [20:0] obs = {dif.state_o, dif.mem_req, dif.mem_we, dif.i_or_d, dif.ir_we, dif.pc_we,
                       dif.pc_src, dif.reg_we, dif.reg_dst, dif.mem_to_reg, dif.alu_src_a,
                       dif.alu_src_b, dif.alu_op, dif.illegal, dif.bus_err};

    function automatic logic [14:0] exp_ctrl(input int s, input logic rdy, input logic z);
        logic mreq, mwe, iod, irwe, pcwe, rwe, rdst, m2r, sa;
        logic [1:0] pcs, sb, aop;
        {mreq, mwe, iod, irwe, pcwe, rwe, rdst, m2r, sa} = '0;
        {pcs, sb, aop} = '0;
        case (s)
            0:  begin mreq = 1; irwe = rdy; pcwe = rdy; sb = 2'd1; end
            1:  sb = 2'd3;
            2:  begin sa = 1; sb = 2'd2; end
            3:  begin mreq = 1; iod = 1; end
            4:  begin rwe = 1; m2r = 1; end
            5:  begin mreq = 1; mwe = 1; iod = 1; end
            6:  begin sa = 1; aop = 2'd2; end
            7:  begin rwe = 1; rdst = 1; end
            8:  begin sa = 1; aop = 2'd1; pcs = 2'd1; pcwe = z; end
            9:  begin pcs = 2'd2; pcwe = 1; end
            10: begin sa = 1; sb = 2'd2; end
            11: rwe = 1;
            default: ;
        endcase
        return {mreq, mwe, iod, irwe, pcwe, pcs, rwe, rdst, m2r, sa, sb, aop};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == T_R) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) || (op == T_J) || (op == T_ADDI);
    endfunction

    task automatic emit(input int s, input logic rdy);
        exp_q.push_back({4'(s), exp_ctrl(s, rdy, cur_z), pend_ill, pend_berr});
        exp_rdy.push_back(rdy);
        exp_op.push_back(cur_op);
        exp_z.push_back(cur_z);
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
    endtask

    // One instruction: state path from the opcode, stretched by wait cycles, cut short by timeout.
    task automatic model_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
        int path[$];
        int s, n;
        cur_op = op;
        cur_z  = z;
        case (op)
            T_R:     path = '{0, 1, 6, 7};
            T_LW:    path = '{0, 1, 2, 3, 4};
            T_SW:    path = '{0, 1, 2, 5};
            T_BEQ:   path = '{0, 1, 8};
            T_J:     path = '{0, 1, 9};
            T_ADDI:  path = '{0, 1, 10, 11};
            default: path = '{0, 1};
        endcase
        foreach (path[i]) begin
            s = path[i];
            n = (s == 0) ? wf : ((s == 3) || (s == 5)) ? wm : 0;
            if (n > TMO) begin
                repeat (TMO + 1) emit(s, 1'b0);
                pend_berr = 1'b1;
                return;
            end
            repeat (n) emit(s, 1'b0);
            emit(s, ((s == 0) || (s == 3) || (s == 5)) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        if (!is_legal(op)) pend_ill = 1'b1;
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); exp_rdy.delete(); exp_op.delete(); exp_z.delete();
    endtask

    task automatic drive_n(input int k);
        int i;
        for (int c = 0; c < k && obs_q.size() < exp_q.size(); c++) begin
            i = obs_q.size();
            dif.mem_ready = exp_rdy[i];
            dif.opcode    = exp_op[i];
            dif.zero      = exp_z[i];
            #1;
            obs_q.push_back(obs);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        dif.mem_ready = 1'b1; dif.opcode = 6'd0; dif.zero = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock); #1;
            total++;
            if (obs !== 21'd0) begin
                bad++; $display("FAIL reset_hold: got %h want %h", obs, 21'd0);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        clear_q();
        model_instr(T_R, 1'b0, 0, 0);
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL reset_release cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_instr_mix();
        clear_q();
        model_instr(T_R, 1'b0, 0, 0);
        model_instr(T_LW, 1'b0, 0, 0);
        model_instr(T_SW, 1'b0, 0, 0);
        model_instr(T_ADDI, 1'b0, 0, 0);
        repeat (20) model_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 0, 0);
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL instr_mix cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        clear_q();
        model_instr(T_BEQ, 1'b1, 0, 0);
        model_instr(T_BEQ, 1'b0, 0, 0);
        model_instr(T_J, 1'b0, 0, 0);
        model_instr(T_J, 1'b1, 0, 0);
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL branch_jump cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        clear_q();
        model_instr(T_LW, 1'b0, 0, 3);
        repeat (15) model_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                                $urandom_range(0, 5), $urandom_range(0, 5));
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL mem_wait cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_q();
        model_instr(T_R, 1'b0, TMO + 1, 0);
        model_instr(T_ADDI, 1'b0, TMO, 0);
        model_instr(T_SW, 1'b0, 0, TMO + 5);
        model_instr(T_LW, 1'b0, 2, TMO + 1);
        model_instr(T_LW, 1'b0, 0, TMO);
        model_instr(T_J, 1'b0, 0, 0);
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL timeout cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op;
        clear_q();
        model_instr(6'b111111, 1'b0, 0, 0);
        model_instr(T_R, 1'b0, 0, 0);
        repeat (4) begin
            do op = 6'($urandom); while (is_legal(op));
            model_instr(op, 1'b0, $urandom_range(0, 2), 0);
            model_instr(legal_ops[$urandom_range(0, 5)], 1'b1, 0, 0);
        end
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL illegal cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midwait();
        clear_q();
        model_instr(T_SW, 1'b0, 0, 5);
        drive_n(6);
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL midwait_pre cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        reset = 1'b0;
        @(negedge clock); #1;
        total++;
        if (obs !== 21'd0) begin
            bad++; $display("FAIL midwait_reset: got %h want %h", obs, 21'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
        clear_q();
        model_instr(T_R, 1'b0, TMO, 0);
        model_instr(T_ADDI, 1'b0, 0, 0);
        drive_n(exp_q.size());
        foreach (obs_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL midwait_post cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        legal_ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        test_reset();
        test_instr_mix();
        test_branch_jump();
        test_mem_wait();
        test_timeout();
        test_illegal();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
